// File: rtl/rpn_sequencer_if.sv
// Token channel from the command decoder into the RPN sequencer.
// A token transfers on any rising clk edge where tok_valid and tok_ready are both high;
// the source holds its fields stable while tok_valid is high and tok_ready is low.
interface rpn_sequencer_if #(
  parameter int W = 10
);
  logic         tok_valid;
  logic         tok_ready;
  logic         tok_is_op;
  logic [W-1:0] tok_data;
  logic         tok_last;

  modport master (
    output tok_valid, tok_is_op, tok_data, tok_last,
    input  tok_ready
  );

  modport slave (
    input  tok_valid, tok_is_op, tok_data, tok_last,
    output tok_ready
  );
endinterface

// File: rtl/rpn_sequencer.sv
// Evaluates RPN token streams on the shared hardware stack; sole master of its push/pop.
// Stack strobes are combinational so an operand is pushed in its own handshake cycle.
module rpn_sequencer #(
  parameter int W     = 10,
  parameter int DEPTH = 7,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  rpn_sequencer_if.slave tok,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [W-1:0]  stk_indata,
  input  logic [W-1:0]  stk_outdata,
  output logic          res_valid,
  output logic [W-1:0]  res_data,
  output logic [1:0]    err_code,
  output logic [DW-1:0] depth,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP_B = 3'd1,
    POP_A = 3'd2,
    EXEC  = 3'd3,
    FIN   = 3'd4,
    DRAIN = 3'd5
  } state_e;

  localparam logic [1:0]    ERR_NONE = 2'd0;
  localparam logic [1:0]    ERR_OVF  = 2'd1;
  localparam logic [1:0]    ERR_UNF  = 2'd2;
  localparam logic [1:0]    ERR_UNB  = 2'd3;
  localparam logic [DW-1:0] DEPTH_C  = DW'(DEPTH);
  localparam logic [DW-1:0] ONE_C    = DW'(1);
  localparam logic [DW-1:0] TWO_C    = DW'(2);

  state_e        state_q;
  logic [DW-1:0] depth_q;
  logic [W-1:0]  a_q, b_q, res_data_q;
  logic [1:0]    op_q, err_q;
  logic          last_q, res_valid_q;
  logic          tok_accept;
  logic [W-1:0]  alu_d;

  assign tok.tok_ready = (state_q == IDLE);
  assign tok_accept    = tok.tok_valid && (state_q == IDLE);

  always_comb begin
    alu_d = '0;
    case (op_q)
      2'd0:    alu_d = a_q + b_q;
      2'd1:    alu_d = a_q - b_q;
      2'd2:    alu_d = a_q & b_q;
      default: alu_d = a_q | b_q;
    endcase
  end

  always_comb begin
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_indata = '0;
    case (state_q)
      IDLE: begin
        // An operand arriving on a full stack is discarded, never pushed.
        if (tok_accept && !tok.tok_is_op && (depth_q != DEPTH_C)) begin
          stk_push   = 1'b1;
          stk_indata = tok.tok_data;
        end
      end
      POP_B, POP_A: stk_pop = 1'b1;
      EXEC: begin
        stk_push   = 1'b1;
        stk_indata = alu_d;
      end
      FIN:     stk_pop = (depth_q == ONE_C);
      DRAIN:   stk_pop = (depth_q != '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      last_q      <= 1'b0;
      err_q       <= ERR_NONE;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tok_accept) begin
            err_q <= ERR_NONE;
            if (!tok.tok_is_op) begin
              if (depth_q == DEPTH_C) begin
                err_q   <= ERR_OVF;
                state_q <= DRAIN;
              end else begin
                depth_q <= depth_q + ONE_C;
                if (tok.tok_last) state_q <= FIN;
              end
            end else begin
              op_q   <= tok.tok_data[1:0];
              last_q <= tok.tok_last;
              if (depth_q < TWO_C) begin
                err_q   <= ERR_UNF;
                state_q <= DRAIN;
              end else begin
                state_q <= POP_B;
              end
            end
          end
        end
        POP_B: begin
          b_q     <= stk_outdata;
          depth_q <= depth_q - ONE_C;
          state_q <= POP_A;
        end
        POP_A: begin
          a_q     <= stk_outdata;
          depth_q <= depth_q - ONE_C;
          state_q <= EXEC;
        end
        EXEC: begin
          depth_q <= depth_q + ONE_C;
          state_q <= last_q ? FIN : IDLE;
        end
        FIN: begin
          if (depth_q == ONE_C) begin
            res_data_q  <= stk_outdata;
            res_valid_q <= 1'b1;
            depth_q     <= '0;
            state_q     <= IDLE;
          end else begin
            err_q   <= ERR_UNB;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (depth_q != '0) depth_q <= depth_q - ONE_C;
          else               state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign err_code  = err_q;
  assign depth     = depth_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer: behavioural stack model, token driver, result scoreboard.
module tb_rpn_sequencer;
  localparam int W     = 10;
  localparam int DEPTH = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         stk_push, stk_pop, res_valid, busy;
  logic [W-1:0] stk_indata, stk_outdata, res_data;
  logic [1:0]   err_code;
  logic [2:0]   depth, dbg_state;

  rpn_sequencer_if #(.W(W)) tok_if ();

  rpn_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tok(tok_if),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_indata(stk_indata),
    .stk_outdata(stk_outdata), .res_valid(res_valid), .res_data(res_data),
    .err_code(err_code), .depth(depth), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Stack model: pushes/pops land at the clock edge, top is a combinational view.
  logic [W-1:0] stk_mem [DEPTH];
  int           sp = 0;
  int           push_cnt = 0;
  int           pop_cnt = 0;
  int           stk_abuse = 0;
  logic [W-1:0] push_log[$];

  assign stk_outdata = (sp > 0) ? stk_mem[sp-1] : '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= 0;
    end else begin
      if (stk_push && stk_pop) stk_abuse <= stk_abuse + 1;
      else if (stk_push) begin
        if (sp >= DEPTH) stk_abuse <= stk_abuse + 1;
        else begin
          stk_mem[sp] <= stk_indata;
          sp          <= sp + 1;
          push_cnt    <= push_cnt + 1;
          push_log.push_back(stk_indata);
        end
      end else if (stk_pop) begin
        if (sp <= 0) stk_abuse <= stk_abuse + 1;
        else begin
          sp      <= sp - 1;
          pop_cnt <= pop_cnt + 1;
        end
      end
    end
  end

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int           res_cnt = 0;

  always @(negedge clk) begin
    if (rst && res_valid) begin
      res_cnt++;
      if (exp_q.size() == 0) check("res_unexpected", 32'(res_data), 32'hFFFF_FFFF);
      else                   check("res_data", 32'(res_data), 32'(exp_q.pop_front()));
    end
  end

  function automatic logic [W-1:0] calc(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic is_op, input logic [W-1:0] data, input logic last);
    int n = 0;
    tok_if.tok_valid = 1'b1;
    tok_if.tok_is_op = is_op;
    tok_if.tok_data  = data;
    tok_if.tok_last  = last;
    while (!tok_if.tok_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    tok_if.tok_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  int p0, r0;
  logic [W-1:0] x, y, z;
  logic [1:0]   o1, o2;

  initial begin
    tok_if.tok_valid = 1'b0;
    tok_if.tok_is_op = 1'b0;
    tok_if.tok_data  = '0;
    tok_if.tok_last  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(tok_if.tok_ready), 32'd1);
    check("rst_push", 32'(stk_push), 32'd0);
    check("rst_pop", 32'(stk_pop), 32'd0);
    check("rst_indata", 32'(stk_indata), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_err", 32'(err_code), 32'd0);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 2 6 + -> 8
    push_log.delete();
    send(1'b0, 10'd2, 1'b0);
    send(1'b0, 10'd6, 1'b0);
    exp_q.push_back(10'd8);
    send(1'b1, 10'd0, 1'b1);
    wait_idle();
    check("add_push_n", 32'(push_log.size()), 32'd3);
    if (push_log.size() == 3) begin
      check("add_push0", 32'(push_log[0]), 32'd2);
      check("add_push1", 32'(push_log[1]), 32'd6);
      check("add_push2", 32'(push_log[2]), 32'd8);
    end
    check("add_depth", 32'(depth), 32'd0);
    check("add_err", 32'(err_code), 32'd0);

    // 2 6 - -> 1020
    exp_q.push_back(10'd1020);
    send(1'b0, 10'd2, 1'b0);
    send(1'b0, 10'd6, 1'b0);
    send(1'b1, 10'd1, 1'b1);
    wait_idle();

    // Overflow on the 8th operand
    push_log.delete();
    for (int i = 1; i <= 7; i++) send(1'b0, W'(i), 1'b0);
    check("ovf_depth_full", 32'(depth), 32'd7);
    p0 = pop_cnt;
    send(1'b0, 10'd8, 1'b0);
    check("ovf_err", 32'(err_code), 32'd1);
    check("ovf_busy", 32'(busy), 32'd1);
    wait_idle();
    check("ovf_pushes", 32'(push_log.size()), 32'd7);
    check("ovf_pops", 32'(pop_cnt - p0), 32'd7);
    check("ovf_depth", 32'(depth), 32'd0);
    check("ovf_ready", 32'(tok_if.tok_ready), 32'd1);
    check("ovf_err_sticky", 32'(err_code), 32'd1);

    // Underflow, then the next operand clears the error
    send(1'b0, 10'd5, 1'b0);
    check("unf_err_cleared", 32'(err_code), 32'd0);
    p0 = pop_cnt;
    send(1'b1, 10'd0, 1'b0);
    check("unf_err", 32'(err_code), 32'd2);
    wait_idle();
    check("unf_pops", 32'(pop_cnt - p0), 32'd1);
    exp_q.push_back(10'd7);
    send(1'b0, 10'd7, 1'b1);
    check("unf_err_clear2", 32'(err_code), 32'd0);
    wait_idle();

    // Unbalanced: two operands left at the end
    r0 = res_cnt;
    p0 = pop_cnt;
    send(1'b0, 10'd3, 1'b0);
    send(1'b0, 10'd4, 1'b1);
    wait_idle();
    check("unb_err", 32'(err_code), 32'd3);
    check("unb_pops", 32'(pop_cnt - p0), 32'd2);
    check("unb_no_result", 32'(res_cnt), 32'(r0));
    check("unb_depth", 32'(depth), 32'd0);

    // Reset in POP_A aborts everything
    send(1'b0, 10'd9, 1'b0);
    send(1'b0, 10'd7, 1'b0);
    send(1'b1, 10'd3, 1'b1);
    @(negedge clk);
    check("abort_in_pop_a", 32'(dbg_state), 32'd2);
    rst = 1'b0;
    #1;
    check("abort_depth", 32'(depth), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pop", 32'(stk_pop), 32'd0);
    check("abort_push", 32'(stk_push), 32'd0);
    check("abort_ready", 32'(tok_if.tok_ready), 32'd1);
    check("abort_err", 32'(err_code), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.push_back(10'd5);
    send(1'b0, 10'd5, 1'b1);
    wait_idle();

    // Random two- and three-operand expressions
    for (int i = 0; i < 8; i++) begin
      x  = W'($urandom_range(0, 1023));
      y  = W'($urandom_range(0, 1023));
      z  = W'($urandom_range(0, 1023));
      o1 = 2'($urandom_range(0, 3));
      o2 = 2'($urandom_range(0, 3));
      send(1'b0, x, 1'b0);
      send(1'b0, y, 1'b0);
      if (i[0]) begin
        exp_q.push_back(calc(o1, x, y));
        send(1'b1, {8'($urandom_range(0, 255)), o1}, 1'b1);
      end else begin
        exp_q.push_back(calc(o2, calc(o1, x, y), z));
        send(1'b1, W'(o1), 1'b0);
        send(1'b0, z, 1'b0);
        send(1'b1, W'(o2), 1'b1);
      end
      wait_idle();
      check("rand_err", 32'(err_code), 32'd0);
    end

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("stack_abuse", 32'(stk_abuse), 32'd0);
    check("stack_empty", 32'(sp), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
